// File: rtl/mwpktfifo_pkg.sv
// Shared constants for the store-and-forward packet FIFO.
// Default geometry, drop counter width and the counter's saturating increment.
package mwpktfifo_pkg;

  localparam int DATAWIDTH_DEF   = 8;
  localparam int ADDRWIDTH_DEF   = 12;
  localparam int MAXPKTS_DEF     = 64;
  localparam int AFULLTHRESH_DEF = 16;

  localparam int DROPCNT_W = 16;
  localparam logic [DROPCNT_W-1:0] DROPCNT_SAT = 16'hFFFF;

  function automatic logic [DROPCNT_W-1:0] dropcnt_inc(input logic [DROPCNT_W-1:0] cnt);
    if (cnt == DROPCNT_SAT) begin
      return cnt;
    end else begin
      return cnt + 16'd1;
    end
  endfunction

endpackage

// File: rtl/mwpktfifo_mc_ram.sv
// Simple dual-port word store for the packet FIFO.
// One write port, one read port with a single registered read stage; the array itself is never reset.
module mwpktfifo_mc_ram #(
  parameter int WIDTH = 9,
  parameter int AW    = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_r [0:(1<<AW)-1];
  logic [WIDTH-1:0] rd_data_r;

  // Array write port
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Registered read port; only the output stage is cleared so reset outputs are defined
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_r <= {WIDTH{1'b0}};
    end else if (rd_en) begin
      rd_data_r <= mem_r[rd_addr];
    end
  end

  assign rd_data = rd_data_r;

endmodule

// File: rtl/mwpktfifo_mc.sv
// Store-and-forward packet FIFO: bytes are written speculatively and only become readable
// once their packet ends with a good CRC; bad, overflowing or excess packets are rolled back.
module mwpktfifo_mc
  import mwpktfifo_pkg::*;
#(
  parameter int DATAWIDTH   = DATAWIDTH_DEF,
  parameter int ADDRWIDTH   = ADDRWIDTH_DEF,
  parameter int MAXPKTS     = MAXPKTS_DEF,
  parameter int AFULLTHRESH = AFULLTHRESH_DEF
) (
  input  logic                 dutclk,
  input  logic                 reset,
  input  logic [DATAWIDTH-1:0] wr_data,
  input  logic                 wr_datavld,
  input  logic                 wr_eop,
  input  logic                 wr_crcok,
  input  logic                 wr_crcbad,
  output logic                 wr_afull,
  input  logic                 rd_en,
  output logic [DATAWIDTH-1:0] rd_data,
  output logic                 rd_datavld,
  output logic                 rd_eop,
  output logic                 rd_empty,
  output logic [7:0]           numofpacket_canhold,
  output logic [DROPCNT_W-1:0] drop_count
);

  localparam int PW = ADDRWIDTH + 1;
  localparam logic [PW-1:0] DEPTH_C   = {1'b1, {ADDRWIDTH{1'b0}}};
  localparam logic [PW-1:0] PTR_ONE_C = {{ADDRWIDTH{1'b0}}, 1'b1};
  localparam logic [7:0]    MAXPKTS_C = 8'(MAXPKTS);

  logic [PW-1:0]        wptr_r, wcommit_r, rptr_r;
  logic [7:0]           pktcnt_r;
  logic                 drop_r;
  logic [DROPCNT_W-1:0] drop_count_r;
  logic                 rd_datavld_r;
  logic [7:0]           canhold_r;
  logic                 afull_r;

  logic [PW-1:0]        free_s;
  logic                 eop_s, crc_good_s, wr_en_s, commit_s, rollback_s;
  logic                 rd_empty_s, rd_fire_s, eop_read_s;
  logic [PW-1:0]        wptr_n_s, wcommit_n_s, rptr_n_s;
  logic [7:0]           pktcnt_n_s;
  logic                 drop_n_s;
  logic [DROPCNT_W-1:0] drop_count_n_s;
  logic [DATAWIDTH:0]   ram_q_s;

  // Write/commit/rollback decisions and next pointer and count values
  always_comb begin
    free_s     = DEPTH_C - (wptr_r - rptr_r);
    eop_s      = wr_datavld & wr_eop;
    crc_good_s = wr_crcok & ~wr_crcbad;
    wr_en_s    = wr_datavld & (free_s != {PW{1'b0}}) & ~drop_r;
    commit_s   = eop_s & crc_good_s & wr_en_s & (pktcnt_r < MAXPKTS_C);
    rollback_s = eop_s & ~commit_s;
    rd_empty_s = (rptr_r == wcommit_r);
    rd_fire_s  = rd_en & ~rd_empty_s;
    // the eop flag of a read word is only known when the registered read returns
    eop_read_s = rd_datavld_r & ram_q_s[DATAWIDTH];

    wptr_n_s       = wptr_r;
    wcommit_n_s    = wcommit_r;
    rptr_n_s       = rptr_r;
    pktcnt_n_s     = pktcnt_r;
    drop_n_s       = drop_r;
    drop_count_n_s = drop_count_r;

    if (rollback_s) begin
      wptr_n_s = wcommit_r;
    end else if (wr_en_s) begin
      wptr_n_s = wptr_r + PTR_ONE_C;
    end else begin
      wptr_n_s = wptr_r;
    end

    if (commit_s) begin
      wcommit_n_s = wptr_r + PTR_ONE_C;
    end else begin
      wcommit_n_s = wcommit_r;
    end

    if (rd_fire_s) begin
      rptr_n_s = rptr_r + PTR_ONE_C;
    end else begin
      rptr_n_s = rptr_r;
    end

    case ({commit_s, eop_read_s})
      2'b10:   pktcnt_n_s = pktcnt_r + 8'd1;
      2'b01:   pktcnt_n_s = pktcnt_r - 8'd1;
      default: pktcnt_n_s = pktcnt_r;
    endcase

    // once full, the rest of the packet is ignored until its eop clears the flag
    if (eop_s) begin
      drop_n_s = 1'b0;
    end else if (wr_datavld && (free_s == {PW{1'b0}})) begin
      drop_n_s = 1'b1;
    end else begin
      drop_n_s = drop_r;
    end

    if (rollback_s) begin
      drop_count_n_s = dropcnt_inc(drop_count_r);
    end else begin
      drop_count_n_s = drop_count_r;
    end
  end

  // Pointer, count and status registers
  always_ff @(posedge dutclk) begin
    if (reset) begin
      wptr_r       <= {PW{1'b0}};
      wcommit_r    <= {PW{1'b0}};
      rptr_r       <= {PW{1'b0}};
      pktcnt_r     <= 8'd0;
      drop_r       <= 1'b0;
      drop_count_r <= {DROPCNT_W{1'b0}};
      rd_datavld_r <= 1'b0;
      canhold_r    <= MAXPKTS_C;
      afull_r      <= 1'b0;
    end else begin
      wptr_r       <= wptr_n_s;
      wcommit_r    <= wcommit_n_s;
      rptr_r       <= rptr_n_s;
      pktcnt_r     <= pktcnt_n_s;
      drop_r       <= drop_n_s;
      drop_count_r <= drop_count_n_s;
      rd_datavld_r <= rd_fire_s;
      canhold_r    <= MAXPKTS_C - pktcnt_r;
      afull_r      <= (32'(free_s) < AFULLTHRESH);
    end
  end

  mwpktfifo_mc_ram #(
    .WIDTH (DATAWIDTH + 1),
    .AW    (ADDRWIDTH)
  ) u_ram (
    .clk     (dutclk),
    .rst     (reset),
    .wr_en   (wr_en_s),
    .wr_addr (wptr_r[ADDRWIDTH-1:0]),
    .wr_data ({wr_eop, wr_data}),
    .rd_en   (rd_fire_s),
    .rd_addr (rptr_r[ADDRWIDTH-1:0]),
    .rd_data (ram_q_s)
  );

  assign rd_data             = ram_q_s[DATAWIDTH-1:0];
  assign rd_eop              = ram_q_s[DATAWIDTH];
  assign rd_datavld          = rd_datavld_r;
  assign rd_empty            = rd_empty_s;
  assign numofpacket_canhold = canhold_r;
  assign wr_afull            = afull_r;
  assign drop_count          = drop_count_r;

endmodule

// File: tb/tb_mwpktfifo_mc.sv
// Bench for mwpktfifo_mc: a default-sized and a small instance share one stimulus stream and
// are each compared every cycle against a queue-based packet model.
module tb_mwpktfifo_mc;

  logic       dutclk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] wr_data = 8'h00;
  logic       wr_datavld = 1'b0;
  logic       wr_eop = 1'b0;
  logic       wr_crcok = 1'b0;
  logic       wr_crcbad = 1'b0;
  logic       rd_en = 1'b0;

  logic        wr_afull_w   [2];
  logic [7:0]  rd_data_w    [2];
  logic        rd_datavld_w [2];
  logic        rd_eop_w     [2];
  logic        rd_empty_w   [2];
  logic [7:0]  canhold_w    [2];
  logic [15:0] drop_count_w [2];

  int n_checks = 0;
  int n_fails  = 0;

  always #5 dutclk = ~dutclk;

  mwpktfifo_mc dut_big (
    .dutclk (dutclk), .reset (reset),
    .wr_data (wr_data), .wr_datavld (wr_datavld), .wr_eop (wr_eop),
    .wr_crcok (wr_crcok), .wr_crcbad (wr_crcbad), .wr_afull (wr_afull_w[0]),
    .rd_en (rd_en), .rd_data (rd_data_w[0]), .rd_datavld (rd_datavld_w[0]),
    .rd_eop (rd_eop_w[0]), .rd_empty (rd_empty_w[0]),
    .numofpacket_canhold (canhold_w[0]), .drop_count (drop_count_w[0])
  );

  mwpktfifo_mc #(.DATAWIDTH(8), .ADDRWIDTH(4), .MAXPKTS(2), .AFULLTHRESH(4)) dut_small (
    .dutclk (dutclk), .reset (reset),
    .wr_data (wr_data), .wr_datavld (wr_datavld), .wr_eop (wr_eop),
    .wr_crcok (wr_crcok), .wr_crcbad (wr_crcbad), .wr_afull (wr_afull_w[1]),
    .rd_en (rd_en), .rd_data (rd_data_w[1]), .rd_datavld (rd_datavld_w[1]),
    .rd_eop (rd_eop_w[1]), .rd_empty (rd_empty_w[1]),
    .numofpacket_canhold (canhold_w[1]), .drop_count (drop_count_w[1])
  );

  // Reference model: committed words, the packet being received, and the visible status
  logic [8:0] m_cq [2][$];
  logic [8:0] m_pq [2][$];
  bit         m_drop [2];
  int         m_dcnt [2];
  int         m_pk   [2];
  bit         m_rv   [2];
  logic [8:0] m_rw   [2];
  int         m_canh [2];
  bit         m_af   [2];

  function automatic int depth_of(input int d);
    return (d == 0) ? 4096 : 16;
  endfunction

  function automatic int maxp_of(input int d);
    return (d == 0) ? 64 : 2;
  endfunction

  function automatic int thr_of(input int d);
    return (d == 0) ? 16 : 4;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input int d);
    int  free;
    bit  dec;
    bit  inc;
    int  canh_n;
    bit  af_n;
    if (reset) begin
      m_cq[d].delete();
      m_pq[d].delete();
      m_drop[d] = 1'b0;
      m_dcnt[d] = 0;
      m_pk[d]   = 0;
      m_rv[d]   = 1'b0;
      m_rw[d]   = 9'h000;
      m_canh[d] = maxp_of(d);
      m_af[d]   = 1'b0;
      return;
    end
    free   = depth_of(d) - (m_cq[d].size() + m_pq[d].size());
    canh_n = maxp_of(d) - m_pk[d];
    af_n   = (free < thr_of(d));
    dec    = m_rv[d] && m_rw[d][8];
    inc    = 1'b0;
    if (rd_en && (m_cq[d].size() > 0)) begin
      m_rw[d] = m_cq[d].pop_front();
      m_rv[d] = 1'b1;
    end else begin
      m_rv[d] = 1'b0;
    end
    if (wr_datavld) begin
      if ((free > 0) && !m_drop[d]) m_pq[d].push_back({wr_eop, wr_data});
      if (wr_eop) begin
        if (wr_crcok && !wr_crcbad && !m_drop[d] && (free > 0) && (m_pk[d] < maxp_of(d))) begin
          for (int i = 0; i < m_pq[d].size(); i++) m_cq[d].push_back(m_pq[d][i]);
          inc = 1'b1;
        end else if (m_dcnt[d] < 65535) begin
          m_dcnt[d]++;
        end
        m_pq[d].delete();
        m_drop[d] = 1'b0;
      end else if (free == 0) begin
        m_drop[d] = 1'b1;
      end
    end
    m_pk[d]   = m_pk[d] + int'(inc) - int'(dec);
    m_canh[d] = canh_n;
    m_af[d]   = af_n;
  endtask

  task automatic check_outputs();
    for (int d = 0; d < 2; d++) begin
      check_val($sformatf("rd_empty%0d", d), 32'(rd_empty_w[d]), 32'(m_cq[d].size() == 0));
      check_val($sformatf("rd_datavld%0d", d), 32'(rd_datavld_w[d]), 32'(m_rv[d]));
      check_val($sformatf("rd_data%0d", d), 32'(rd_data_w[d]), 32'(m_rw[d][7:0]));
      check_val($sformatf("rd_eop%0d", d), 32'(rd_eop_w[d]), 32'(m_rw[d][8]));
      check_val($sformatf("canhold%0d", d), 32'(canhold_w[d]), 32'(m_canh[d]));
      check_val($sformatf("wr_afull%0d", d), 32'(wr_afull_w[d]), 32'(m_af[d]));
      check_val($sformatf("drop_count%0d", d), 32'(drop_count_w[d]), 32'(m_dcnt[d]));
    end
  endtask

  task automatic tick(input logic v, input logic [7:0] dat, input logic e, input logic ok,
                      input logic bad, input logic rd, input logic rs);
    wr_datavld = v;
    wr_data    = dat;
    wr_eop     = e;
    wr_crcok   = ok;
    wr_crcbad  = bad;
    rd_en      = rd;
    reset      = rs;
    @(posedge dutclk);
    model_step(0);
    model_step(1);
    @(negedge dutclk);
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic read_n(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic send_pkt(input int n, input logic [7:0] base, input logic ok, input logic bad);
    for (int i = 0; i < n; i++)
      tick(1'b1, base + 8'(i), (i == n - 1), ok, bad, 1'b0, 1'b0);
  endtask

  initial begin
    int rd_pct;
    // reset state
    for (int i = 0; i < 3; i++) tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);

    // good 5-byte packet then read it back
    send_pkt(5, 8'h01, 1'b1, 1'b0);
    idle(1);
    read_n(6);
    idle(2);

    // bad CRC packet, and both crc flags equal
    send_pkt(10, 8'h10, 1'b0, 1'b1);
    send_pkt(2, 8'h18, 1'b1, 1'b1);
    send_pkt(2, 8'h1c, 1'b0, 1'b0);
    idle(2);

    // 20-byte packet overflows the small instance, then a short packet
    send_pkt(20, 8'h20, 1'b1, 1'b0);
    send_pkt(3, 8'h40, 1'b1, 1'b0);
    idle(1);
    read_n(24);
    idle(2);

    // packet limit on the small instance
    send_pkt(1, 8'h50, 1'b1, 1'b0);
    send_pkt(1, 8'h51, 1'b1, 1'b0);
    send_pkt(1, 8'h52, 1'b1, 1'b0);
    idle(2);
    read_n(1);
    idle(2);
    send_pkt(1, 8'h53, 1'b1, 1'b0);
    idle(1);
    read_n(4);
    idle(2);

    // commit of B coincides with the returned eop of A
    send_pkt(2, 8'h60, 1'b1, 1'b0);
    tick(1'b1, 8'h70, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(1'b1, 8'h71, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(1'b1, 8'h72, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);
    read_n(4);
    idle(2);

    // reset on the 3rd byte of a packet
    tick(1'b1, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 8'h82, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1);
    send_pkt(2, 8'h90, 1'b1, 1'b0);
    idle(1);
    read_n(3);
    idle(2);

    // randomized traffic with alternating read pressure
    for (int c = 0; c < 4000; c++) begin
      rd_pct = ((c / 500) % 2 == 0) ? 70 : 15;
      tick(($urandom % 100) < 60, 8'($urandom), ($urandom % 6) == 0, ($urandom % 8) != 0,
           ($urandom % 8) == 0, ($urandom % 100) < rd_pct, ($urandom % 800) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
